// File: rtl/alu_uart_sequencer_pkg.sv
// Shared definitions for the ALU/UART sequencer: opcodes, flag bit indices, FSM states.
// Optional feature macro: ALU_FLAGS_TX_EN adds the flag-byte transmit states.
package alu_uart_sequencer_pkg;

  localparam logic [3:0] OP_ADD = 4'h8;
  localparam logic [3:0] OP_SUB = 4'hA;
  localparam logic [3:0] OP_AND = 4'hC;
  localparam logic [3:0] OP_OR  = 4'hD;
  localparam logic [3:0] OP_XOR = 4'hE;
  localparam logic [3:0] OP_SRA = 4'h3;
  localparam logic [3:0] OP_SRL = 4'h2;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_EXC   = 4;

  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
`ifdef ALU_FLAGS_TX_EN
    ,
    ST_SEND_FLAGS = 3'd6,
    ST_WAIT_FLAGS = 3'd7
`endif
  } state_t;

endpackage

// File: rtl/alu_uart_sequencer_frame_timeout_counter.sv
// Inter-byte idle counter: clears on demand, counts while enabled, saturates at TIMEOUT_CYCLES-1.
// expire is combinational and only asserted while enabled; TIMEOUT_CYCLES=0 disables it entirely.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LIMIT = LIMIT_I[CW-1:0];

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT_CYCLES > 0) && enable && (count == LIMIT);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Byte-serial front end for the combinational ALU: collects A, B, opcode from RX, returns result on TX.
// Optional macro ALU_FLAGS_TX_EN: also transmits {3'b000, flags} after the result byte.
module alu_uart_sequencer
  import alu_uart_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [3:0]            o_alu_op,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [4:0]            i_alu_flags,
  output logic                  o_busy,
  output logic                  o_error
);

  state_t state_q, state_d;
  logic   collecting, rx_accept, tmo_expire, tmo_hit;

  assign collecting = (state_q == ST_GET_A) || (state_q == ST_GET_B) || (state_q == ST_GET_OP);
  assign rx_accept  = collecting && i_rx_done;
  // A byte arriving in the expiry cycle still counts as in time.
  assign tmo_hit    = tmo_expire && !i_rx_done;

  frame_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (i_clock),
    .rst_n  (i_reset),
    .clear  (rx_accept || (state_q == ST_GET_A)),
    .enable ((state_q == ST_GET_B) || (state_q == ST_GET_OP)),
    .expire (tmo_expire)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= ST_GET_A;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GET_A:   if (i_rx_done) state_d = ST_GET_B;
      ST_GET_B:   if (i_rx_done) state_d = ST_GET_OP; else if (tmo_hit) state_d = ST_GET_A;
      ST_GET_OP:  if (i_rx_done) state_d = ST_EXEC;   else if (tmo_hit) state_d = ST_GET_A;
      ST_EXEC:    state_d = ST_SEND;
      ST_SEND:    state_d = ST_WAIT_TX;
`ifdef ALU_FLAGS_TX_EN
      ST_WAIT_TX:    if (i_tx_done) state_d = ST_SEND_FLAGS;
      ST_SEND_FLAGS: state_d = ST_WAIT_FLAGS;
      ST_WAIT_FLAGS: if (i_tx_done) state_d = ST_GET_A;
`else
      ST_WAIT_TX: if (i_tx_done) state_d = ST_GET_A;
`endif
      default:    state_d = ST_GET_A;
    endcase
  end

  always_comb begin
    o_busy     = (state_q != ST_GET_A);
    o_tx_start = (state_q == ST_SEND);
`ifdef ALU_FLAGS_TX_EN
    o_tx_start = o_tx_start || (state_q == ST_SEND_FLAGS);
`endif
    o_error    = ((state_q == ST_EXEC) && i_alu_flags[FLAG_EXC]) || tmo_hit;
  end

`ifdef ALU_FLAGS_TX_EN
  logic [4:0] flags_q;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
`ifdef ALU_FLAGS_TX_EN
      flags_q   <= '0;
`endif
    end else begin
      if ((state_q == ST_GET_A) && i_rx_done)  o_alu_a  <= i_rx_data;
      if ((state_q == ST_GET_B) && i_rx_done)  o_alu_b  <= i_rx_data;
      if ((state_q == ST_GET_OP) && i_rx_done) o_alu_op <= i_rx_data[3:0];
      if (state_q == ST_EXEC) begin
        o_tx_data <= i_alu_flags[FLAG_EXC] ? '0 : i_alu_result;
`ifdef ALU_FLAGS_TX_EN
        flags_q   <= i_alu_flags;
`endif
      end
`ifdef ALU_FLAGS_TX_EN
      // Flag byte is loaded as the result byte completes so it is stable when SEND_FLAGS pulses.
      if ((state_q == ST_WAIT_TX) && i_tx_done) o_tx_data <= DATA_WIDTH'(flags_q);
`endif
    end
  end

endmodule
